// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32 pipeline stage registers: default bundle
// widths and the bit layout of the control bundle, so every stage boundary
// agrees on where Rd, MEM_wen, WB_sel and Reg_WB live.
package pipe_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_SKID   = 1;
  localparam int DEF_CNT_W  = 16;

  localparam int CTRL_RD_LSB  = 0;
  localparam int CTRL_RD_MSB  = 4;
  localparam int CTRL_MEM_WEN = 5;
  localparam int CTRL_WB_SEL  = 6;
  localparam int CTRL_REG_WB  = 7;

  typedef struct packed {
    logic       reg_wb;
    logic       wb_sel;
    logic       mem_wen;
    logic [4:0] rd;
  } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for stage perf counters.
// Sticks at all-ones instead of wrapping so a long stall never reads small.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear wins over increment; increment stops once all bits are set.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register carrying a data and a control bundle with a
// valid/ready handshake, flush-to-bubble and an optional two-entry skid buffer.
// Control bits are forced to zero whenever the output entry is not valid, so a
// bubble can never trigger a memory write or a register writeback.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int SKID   = DEF_SKID,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_cnt
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              up_fire;
  logic              down_fire;

  assign up_fire   = in_valid && in_ready;
  assign down_fire = main_valid && out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;

  generate
    if (SKID == 0) begin : g_direct

      assign in_ready = out_ready || !main_valid;

      // Single register: load on accept, drain to a bubble, hold while stalled.
      always_ff @(posedge clk) begin
        if (reset) begin
          main_valid <= 1'b0;
          main_data  <= '0;
          main_ctrl  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
        end else if (up_fire) begin
          main_valid <= 1'b1;
          main_data  <= in_data;
          main_ctrl  <= in_ctrl;
        end else if (down_fire) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
        end
      end

    end else begin : g_skid

      logic              skid_valid;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;

      assign in_ready = !skid_valid;

      // Main plus skid entry kept in FIFO order; the skid slot only fills when
      // the main entry is stalled, and empties into main on the next drain.
      always_ff @(posedge clk) begin
        if (reset) begin
          main_valid <= 1'b0;
          main_data  <= '0;
          main_ctrl  <= '0;
          skid_valid <= 1'b0;
          skid_data  <= '0;
          skid_ctrl  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
        end else if (down_fire && skid_valid) begin
          main_data  <= skid_data;
          main_ctrl  <= skid_ctrl;
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
        end else if (up_fire) begin
          if (main_valid && !out_ready) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_ctrl  <= in_ctrl;
          end else begin
            main_valid <= 1'b1;
            main_data  <= in_data;
            main_ctrl  <= in_ctrl;
          end
        end else if (down_fire) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
        end
      end

    end
  endgenerate

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (main_valid && !out_ready),
    .clr  (clr_cnt),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid instance (4-bit stall counter)
// and one single-register instance. Accepted entries are queued as expected
// results and a per-instance monitor pops and compares on each output transfer.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
  } item_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_clr_cnt;
  logic [63:0] s_in_data, s_out_data;
  logic [7:0]  s_in_ctrl, s_out_ctrl;
  logic [3:0]  s_stall_cnt;

  logic        p_flush, p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_clr_cnt;
  logic [63:0] p_in_data, p_out_data;
  logic [7:0]  p_in_ctrl, p_out_ctrl;
  logic [15:0] p_stall_cnt;

  item_t q_skid[$];
  item_t q_pass[$];
  int    n_skid = 0;
  int    n_pass = 0;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  int    base;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .reset(reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_ctrl(s_in_ctrl),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .stall_cnt(s_stall_cnt), .clr_cnt(s_clr_cnt)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_pass (
    .clk(clk), .reset(reset), .flush(p_flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data), .in_ctrl(p_in_ctrl),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data), .out_ctrl(p_out_ctrl),
    .stall_cnt(p_stall_cnt), .clr_cnt(p_clr_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of directed stimulus on instance sel (1 = skid, 0 = single register).
  task automatic applyStimulus(input int sel, input logic v, input logic [63:0] d,
                               input logic [7:0] c, input logic ordy, input logic fl,
                               input logic clr);
    item_t it;
    it.data = d;
    it.ctrl = c;
    if (sel == 1) begin
      s_in_valid = v; s_in_data = d; s_in_ctrl = c; s_out_ready = ordy; s_flush = fl; s_clr_cnt = clr;
    end else begin
      p_in_valid = v; p_in_data = d; p_in_ctrl = c; p_out_ready = ordy; p_flush = fl; p_clr_cnt = clr;
    end
    @(negedge clk);
    if (sel == 1) begin
      if (fl) q_skid.delete();
      else if (v && s_in_ready) q_skid.push_back(it);
    end else begin
      if (fl) q_pass.delete();
      else if (v && p_in_ready) q_pass.push_back(it);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q_skid.delete();
    q_pass.delete();
  endtask

  // Skid instance monitor: compare every output transfer, and check bubbles carry no control.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (s_out_valid && s_out_ready) begin
        if (q_skid.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL skid unexpected output: got %0h expected none", s_out_data);
        end else begin
          item_t e;
          e = q_skid.pop_front();
          checkOutput("skid out_data", s_out_data, e.data);
          checkOutput("skid out_ctrl", {56'h0, s_out_ctrl}, {56'h0, e.ctrl});
          n_skid++;
        end
      end
      if (!s_out_valid) checkOutput("skid bubble ctrl", {56'h0, s_out_ctrl}, 64'h0);
    end
  end

  // Single-register instance monitor, same checks.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (p_out_valid && p_out_ready) begin
        if (q_pass.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL pass unexpected output: got %0h expected none", p_out_data);
        end else begin
          item_t e;
          e = q_pass.pop_front();
          checkOutput("pass out_data", p_out_data, e.data);
          checkOutput("pass out_ctrl", {56'h0, p_out_ctrl}, {56'h0, e.ctrl});
          n_pass++;
        end
      end
      if (!p_out_valid) checkOutput("pass bubble ctrl", {56'h0, p_out_ctrl}, 64'h0);
    end
  end

  initial begin
    s_flush = 0; s_in_valid = 0; s_in_data = '0; s_in_ctrl = '0; s_out_ready = 1; s_clr_cnt = 0;
    p_flush = 0; p_in_valid = 0; p_in_data = '0; p_in_ctrl = '0; p_out_ready = 1; p_clr_cnt = 0;
    @(posedge clk);
    #1;
    doReset();
    mon_en = 1'b1;

    checkOutput("reset s_out_valid", {63'h0, s_out_valid}, 64'h0);
    checkOutput("reset s_out_data", s_out_data, 64'h0);
    checkOutput("reset s_out_ctrl", {56'h0, s_out_ctrl}, 64'h0);
    checkOutput("reset s_stall_cnt", {60'h0, s_stall_cnt}, 64'h0);
    checkOutput("reset s_in_ready", {63'h0, s_in_ready}, 64'h1);
    checkOutput("reset p_in_ready", {63'h0, p_in_ready}, 64'h1);
    checkOutput("reset p_stall_cnt", {48'h0, p_stall_cnt}, 64'h0);

    // Streaming 1..5 at full rate
    base = n_skid;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 1'b1, 64'(i), 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("t1 out_valid %0d", i), {63'h0, s_out_valid}, 64'h1);
      checkOutput($sformatf("t1 out_data %0d", i), s_out_data, 64'(i));
    end
    applyStimulus(1, 1'b0, 64'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 64'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1 drained", {63'h0, s_out_valid}, 64'h0);
    checkOutput("t1 count", 64'(n_skid - base), 64'd5);
    checkOutput("t1 stall_cnt", {60'h0, s_stall_cnt}, 64'h0);

    // Skid fill under stall, release in order
    base = n_skid;
    applyStimulus(1, 1'b1, 64'hA, 8'h0A, 1'b0, 1'b0, 1'b0);
    checkOutput("t2 in_ready after A", {63'h0, s_in_ready}, 64'h1);
    applyStimulus(1, 1'b1, 64'hB, 8'h0B, 1'b0, 1'b0, 1'b0);
    checkOutput("t2 in_ready after B", {63'h0, s_in_ready}, 64'h0);
    applyStimulus(1, 1'b1, 64'hC, 8'h0C, 1'b0, 1'b0, 1'b0);
    checkOutput("t2 in_ready held", {63'h0, s_in_ready}, 64'h0);
    checkOutput("t2 out_data held", s_out_data, 64'hA);
    applyStimulus(1, 1'b1, 64'hC, 8'h0C, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 64'hC, 8'h0C, 1'b1, 1'b0, 1'b0);
    checkOutput("t2 in_ready reopen", {63'h0, s_in_ready}, 64'h1);
    checkOutput("t2 stall_cnt", {60'h0, s_stall_cnt}, 64'd3);
    applyStimulus(1, 1'b1, 64'hC, 8'h0C, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 64'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("t2 count", 64'(n_skid - base), 64'd3);
    checkOutput("t2 stall_cnt final", {60'h0, s_stall_cnt}, 64'd3);

    // Flush at occupancy 2, then flush discarding an offered entry
    applyStimulus(1, 1'b1, 64'h11, 8'hFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 64'h22, 8'hFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 64'h33, 8'hFF, 1'b0, 1'b1, 1'b0);
    checkOutput("t3 out_valid", {63'h0, s_out_valid}, 64'h0);
    checkOutput("t3 out_ctrl", {56'h0, s_out_ctrl}, 64'h0);
    checkOutput("t3 in_ready", {63'h0, s_in_ready}, 64'h1);
    applyStimulus(1, 1'b1, 64'h44, 8'hFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 64'h55, 8'h5A, 1'b0, 1'b1, 1'b0);
    checkOutput("t3b out_valid", {63'h0, s_out_valid}, 64'h0);
    checkOutput("t3b in_ready", {63'h0, s_in_ready}, 64'h1);
    applyStimulus(1, 1'b0, 64'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3 discard", {63'h0, s_out_valid}, 64'h0);
    checkOutput("t3 stall_cnt", {60'h0, s_stall_cnt}, 64'd6);

    // Reset in the middle of a full stall
    applyStimulus(1, 1'b1, 64'h71, 8'h3C, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 64'h72, 8'h3C, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 64'h73, 8'h3C, 1'b0, 1'b0, 1'b0);
    checkOutput("t4 pre stall_cnt", {60'h0, s_stall_cnt}, 64'd8);
    doReset();
    checkOutput("t4 out_valid", {63'h0, s_out_valid}, 64'h0);
    checkOutput("t4 out_data", s_out_data, 64'h0);
    checkOutput("t4 out_ctrl", {56'h0, s_out_ctrl}, 64'h0);
    checkOutput("t4 in_ready", {63'h0, s_in_ready}, 64'h1);
    checkOutput("t4 stall_cnt", {60'h0, s_stall_cnt}, 64'h0);

    // Counter saturation and clear
    applyStimulus(1, 1'b1, 64'h5, 8'h03, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5 saturated", {60'h0, s_stall_cnt}, 64'd15);
    applyStimulus(1, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("t5 cleared", {60'h0, s_stall_cnt}, 64'd0);
    applyStimulus(1, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5 restart", {60'h0, s_stall_cnt}, 64'd1);
    applyStimulus(1, 1'b0, 64'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5 drained", {63'h0, s_out_valid}, 64'h0);

    // Single-register instance with toggling out_ready
    base = n_pass;
    applyStimulus(0, 1'b1, 64'h60, 8'h21, 1'b1, 1'b0, 1'b0);
    checkOutput("t6 in_ready s1", {63'h0, p_in_ready}, 64'h1);
    applyStimulus(0, 1'b1, 64'h61, 8'h22, 1'b0, 1'b0, 1'b0);
    checkOutput("t6 in_ready s2", {63'h0, p_in_ready}, 64'h0);
    applyStimulus(0, 1'b1, 64'h61, 8'h22, 1'b1, 1'b0, 1'b0);
    checkOutput("t6 in_ready s3", {63'h0, p_in_ready}, 64'h1);
    applyStimulus(0, 1'b1, 64'h62, 8'h23, 1'b0, 1'b0, 1'b0);
    checkOutput("t6 in_ready s4", {63'h0, p_in_ready}, 64'h0);
    applyStimulus(0, 1'b1, 64'h62, 8'h23, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 64'h63, 8'h24, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 64'h63, 8'h24, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 64'h64, 8'h25, 1'b0, 1'b0, 1'b0);
    checkOutput("t6 out_data s8", p_out_data, 64'h63);
    applyStimulus(0, 1'b0, 64'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 64'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("t6 count", 64'(n_pass - base), 64'd4);
    checkOutput("t6 stall_cnt", {48'h0, p_stall_cnt}, 64'd4);

    checkOutput("skid queue empty", 64'(q_skid.size()), 64'd0);
    checkOutput("pass queue empty", 64'(q_pass.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
